// File: rtl/data_order_check.sv
// data_order_check: per-channel counting-pattern checker with lock, mismatch pulse, sticky flag and saturating count.
// Define DATA_ORDER_CHECK_RESYNC_EN to resynchronise the prediction to the received value on a mismatch.
module data_order_check #(
  parameter int NUM_CHANNELS   = 4,
  parameter int CHANNEL_OFFSET = 1024,
  parameter int CHANNEL_WIDTH  = 16,
  parameter int ERR_WIDTH      = 16,
  parameter int STRICT_START   = 0
) (
  input  logic                                    adc_clk,
  input  logic                                    adc_rstn,
  input  logic                                    check_en,
  input  logic                                    reset_count,
  input  logic [NUM_CHANNELS*CHANNEL_WIDTH-1:0]   adc_data_in,
  input  logic [NUM_CHANNELS-1:0]                 adc_enable_in,
  input  logic [NUM_CHANNELS-1:0]                 adc_valid_in,
  output logic [NUM_CHANNELS-1:0]                 check_lock,
  output logic [NUM_CHANNELS-1:0]                 check_err_pulse,
  output logic [NUM_CHANNELS-1:0]                 check_err,
  output logic [NUM_CHANNELS*ERR_WIDTH-1:0]       err_count
);
  typedef enum logic [1:0] {IDLE, WAIT_SEED, TRACK} state_t;
  localparam logic [CHANNEL_WIDTH-1:0] ONE_D = CHANNEL_WIDTH'(1);
  localparam logic [ERR_WIDTH-1:0] ONE_E = ERR_WIDTH'(1);
  localparam logic [ERR_WIDTH-1:0] ERR_MAX = '1;
`ifdef DATA_ORDER_CHECK_RESYNC_EN
  localparam bit RESYNC = 1'b1;
`else
  localparam bit RESYNC = 1'b0;
`endif
  logic rst;
  assign rst = !adc_rstn || reset_count;
  genvar i;
  for (i = 0; i < NUM_CHANNELS; i++) begin : g_ch
    localparam logic [CHANNEL_WIDTH-1:0] SEED = CHANNEL_WIDTH'(CHANNEL_OFFSET * i);
    state_t st_q, st_d;
    logic [CHANNEL_WIDTH-1:0] exp_q, exp_d, d;
    logic [ERR_WIDTH-1:0] cnt_q, cnt_d;
    logic lock_q, pulse_q, err_q, qual, seed_ok, mis;
    assign d = adc_data_in[CHANNEL_WIDTH*i +: CHANNEL_WIDTH];
    assign qual = adc_enable_in[i] && adc_valid_in[i] && check_en;
    assign seed_ok = (STRICT_START == 0) || (d == SEED);
    // A strict-start channel counts a wrong first value as an error but keeps waiting for the seed.
    assign mis = qual && ((st_q == WAIT_SEED && !seed_ok) || (st_q == TRACK && d != exp_q));
    always_comb begin
      st_d = !check_en ? IDLE :
             st_q == IDLE ? WAIT_SEED :
             (st_q == WAIT_SEED && qual && seed_ok) ? TRACK : st_q;
      exp_d = exp_q;
      if (qual && st_q == WAIT_SEED && seed_ok) exp_d = d + ONE_D;
      else if (qual && st_q == TRACK) exp_d = (mis && RESYNC) ? d + ONE_D : exp_q + ONE_D;
      cnt_d = (mis && cnt_q != ERR_MAX) ? cnt_q + ONE_E : cnt_q;
    end
    always_ff @(posedge adc_clk) begin
      if (rst) begin
        st_q    <= check_en ? WAIT_SEED : IDLE;
        exp_q   <= '0;
        cnt_q   <= '0;
        lock_q  <= 1'b0;
        pulse_q <= 1'b0;
        err_q   <= 1'b0;
      end else begin
        st_q    <= st_d;
        exp_q   <= exp_d;
        cnt_q   <= cnt_d;
        lock_q  <= st_d == TRACK;
        pulse_q <= mis;
        err_q   <= err_q || mis;
      end
    end
    assign check_lock[i] = lock_q;
    assign check_err_pulse[i] = pulse_q;
    assign check_err[i] = err_q;
    assign err_count[ERR_WIDTH*i +: ERR_WIDTH] = cnt_q;
  end
endmodule

// File: tb/tb_data_order_check.sv
// tb_data_order_check: table vectors, hand sequences and random traffic against a behavioural channel model.
module tb_data_order_check;
  localparam int N = 4, CW = 16, EW = 4, OFF = 1024;
  logic adc_clk = 1'b0, adc_rstn = 1'b0, check_en = 1'b0, reset_count = 1'b0;
  logic [N*CW-1:0] adc_data_in = '0;
  logic [N-1:0] adc_enable_in = '0, adc_valid_in = '0;
  logic [N-1:0] check_lock, check_err_pulse, check_err;
  logic [N*EW-1:0] err_count;
  logic [N-1:0] u1_lock, u1_pulse, u1_err;
  logic [N*EW-1:0] u1_cnt;
  int total = 0, bad = 0;

  data_order_check #(.NUM_CHANNELS(N), .CHANNEL_OFFSET(OFF), .CHANNEL_WIDTH(CW), .ERR_WIDTH(EW), .STRICT_START(1)) dut (
    .adc_clk(adc_clk), .adc_rstn(adc_rstn), .check_en(check_en), .reset_count(reset_count),
    .adc_data_in(adc_data_in), .adc_enable_in(adc_enable_in), .adc_valid_in(adc_valid_in),
    .check_lock(check_lock), .check_err_pulse(check_err_pulse), .check_err(check_err), .err_count(err_count));

  data_order_check #(.NUM_CHANNELS(N), .CHANNEL_OFFSET(32768), .CHANNEL_WIDTH(CW), .ERR_WIDTH(EW), .STRICT_START(0)) u1 (
    .adc_clk(adc_clk), .adc_rstn(adc_rstn), .check_en(check_en), .reset_count(reset_count),
    .adc_data_in(adc_data_in), .adc_enable_in(adc_enable_in), .adc_valid_in(adc_valid_in),
    .check_lock(u1_lock), .check_err_pulse(u1_pulse), .check_err(u1_err), .err_count(u1_cnt));

  always #5 adc_clk = ~adc_clk;

`ifdef DATA_ORDER_CHECK_RESYNC_EN
  localparam bit RESYNC = 1'b1;
`else
  localparam bit RESYNC = 1'b0;
`endif

  // Reference model: "armed" means check_en was high at the previous edge; "locked" means tracking.
  bit m_armed;
  bit m_lock[N], m_err[N], m_pulse[N];
  int m_exp[N], m_cnt[N];

  function automatic int seed(int c);
    return (OFF * c) % 65536;
  endfunction

  task automatic model_step(input bit rst, input bit en, input logic [3:0] ev, input logic [63:0] data);
    for (int c = 0; c < N; c++) begin
      int dv;
      dv = int'(data[c*CW +: CW]);
      m_pulse[c] = 1'b0;
      if (rst) begin
        m_lock[c] = 1'b0; m_err[c] = 1'b0; m_exp[c] = 0; m_cnt[c] = 0;
      end else if (!en) m_lock[c] = 1'b0;
      else if (m_armed && ev[c]) begin
        if (!m_lock[c] && dv == seed(c)) begin
          m_lock[c] = 1'b1; m_exp[c] = (dv + 1) % 65536;
        end else if (m_lock[c] && dv == m_exp[c]) m_exp[c] = (m_exp[c] + 1) % 65536;
        else begin
          m_pulse[c] = 1'b1; m_err[c] = 1'b1;
          m_cnt[c] = (m_cnt[c] < 15) ? m_cnt[c] + 1 : 15;
          if (m_lock[c]) m_exp[c] = RESYNC ? (dv + 1) % 65536 : (m_exp[c] + 1) % 65536;
        end
      end
    end
    m_armed = en;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  task automatic cyc(input logic rstn, input logic rc, input logic en, input logic [3:0] ev, input logic [63:0] data);
    logic [3:0] ml, mp, me;
    logic [15:0] mc;
    adc_rstn = rstn; reset_count = rc; check_en = en;
    adc_enable_in = ev; adc_valid_in = ev; adc_data_in = data;
    @(posedge adc_clk);
    model_step(!rstn || rc, en, ev, data);
    #1;
    for (int c = 0; c < N; c++) begin
      ml[c] = m_lock[c]; mp[c] = m_pulse[c]; me[c] = m_err[c]; mc[c*EW +: EW] = 4'(m_cnt[c]);
    end
    check("lock", 64'(check_lock), 64'(ml));
    check("pulse", 64'(check_err_pulse), 64'(mp));
    check("err", 64'(check_err), 64'(me));
    check("count", 64'(err_count), 64'(mc));
  endtask

  typedef struct {
    logic rc; logic en; logic [3:0] ev; logic [63:0] data;
    logic [3:0] lock; logic [3:0] pulse; logic [3:0] err;
  } vec_t;
  vec_t tbl[11];
  localparam logic [3:0] SLIP = RESYNC ? 4'b0000 : 4'b0100;

  initial begin
    logic [63:0] dd;
    tbl[0]  = '{1'b1, 1'b1, 4'b0000, 64'h0, 4'b0000, 4'b0000, 4'b0000};
    tbl[1]  = '{1'b0, 1'b1, 4'b0101, {16'd0, 16'd2048, 16'd0, 16'd5}, 4'b0100, 4'b0001, 4'b0001};
    tbl[2]  = '{1'b0, 1'b1, 4'b0101, {16'd0, 16'd2049, 16'd0, 16'd0}, 4'b0101, 4'b0000, 4'b0001};
    tbl[3]  = '{1'b0, 1'b1, 4'b0101, {16'd0, 16'd2051, 16'd0, 16'd1}, 4'b0101, 4'b0100, 4'b0101};
    tbl[4]  = '{1'b0, 1'b1, 4'b0101, {16'd0, 16'd2052, 16'd0, 16'd2}, 4'b0101, SLIP,    4'b0101};
    tbl[5]  = '{1'b0, 1'b1, 4'b0101, {16'd0, 16'd2053, 16'd0, 16'd3}, 4'b0101, SLIP,    4'b0101};
    tbl[6]  = '{1'b1, 1'b1, 4'b0101, {16'd0, 16'd2054, 16'd0, 16'd4}, 4'b0000, 4'b0000, 4'b0000};
    tbl[7]  = '{1'b0, 1'b1, 4'b0101, {16'd0, 16'd2048, 16'd0, 16'd0}, 4'b0101, 4'b0000, 4'b0000};
    tbl[8]  = '{1'b0, 1'b0, 4'b0101, {16'd0, 16'd2049, 16'd0, 16'd1}, 4'b0000, 4'b0000, 4'b0000};
    tbl[9]  = '{1'b0, 1'b1, 4'b0001, {16'd0, 16'd0, 16'd0, 16'd1},    4'b0000, 4'b0000, 4'b0000};
    tbl[10] = '{1'b0, 1'b1, 4'b0101, {16'd0, 16'd2048, 16'd0, 16'd0}, 4'b0101, 4'b0000, 4'b0000};
    m_armed = 1'b0;
    for (int c = 0; c < N; c++) begin
      m_lock[c] = 0; m_err[c] = 0; m_pulse[c] = 0; m_exp[c] = 0; m_cnt[c] = 0;
    end
    cyc(1'b0, 1'b0, 1'b1, 4'b0000, 64'h0);
    check("reset_lock", 64'(check_lock), 64'h0);
    check("reset_count", 64'(err_count), 64'h0);
    for (int k = 0; k < 11; k++) begin
      cyc(1'b1, tbl[k].rc, tbl[k].en, tbl[k].ev, tbl[k].data);
      check($sformatf("tbl%0d_lock", k), 64'(check_lock), 64'(tbl[k].lock));
      check($sformatf("tbl%0d_pulse", k), 64'(check_err_pulse), 64'(tbl[k].pulse));
      check($sformatf("tbl%0d_err", k), 64'(check_err), 64'(tbl[k].err));
    end
    // Ideal streams on every channel, checked against fixed expectations too.
    cyc(1'b1, 1'b1, 1'b1, 4'b0000, 64'h0);
    for (int s = 0; s < 100; s++) begin
      cyc(1'b1, 1'b0, 1'b1, 4'b1111, {16'(3072 + s), 16'(2048 + s), 16'(1024 + s), 16'(s)});
      check("ideal_lock", 64'(check_lock), 64'hF);
    end
    check("ideal_count", 64'(err_count), 64'h0);
    check("ideal_err", 64'(check_err), 64'h0);
    // Non-strict instance: first sample seeds, then the count wraps through zero.
    cyc(1'b1, 1'b1, 1'b1, 4'b0000, 64'h0);
    for (int s = 0; s < 4; s++) begin
      dd = '0;
      dd[31:16] = 16'(32'hFFFE + s);
      cyc(1'b1, 1'b0, 1'b1, 4'b0010, dd);
      check("wrap_lock", 64'(u1_lock), 64'h2);
      check("wrap_pulse", 64'(u1_pulse), 64'h0);
      check("wrap_count", 64'(u1_cnt), 64'h0);
    end
    // Continuous mismatches on ch3 saturate its 4-bit counter.
    cyc(1'b1, 1'b1, 1'b1, 4'b0000, 64'h0);
    for (int s = 0; s < 20; s++) cyc(1'b1, 1'b0, 1'b1, 4'b1000, {16'h1234, 48'h0});
    check("sat_count", 64'(err_count[15:12]), 64'd15);
    check("sat_pulse", 64'(check_err_pulse[3]), 64'd1);
    cyc(1'b1, 1'b0, 1'b1, 4'b0000, 64'h0);
    check("sat_pulse_gap", 64'(check_err_pulse[3]), 64'd0);
    // Random traffic, mostly well-ordered, with occasional slips, resets and disables.
    for (int s = 0; s < 2000; s++) begin
      for (int c = 0; c < N; c++) begin
        int good;
        good = m_lock[c] ? m_exp[c] : seed(c);
        dd[c*CW +: CW] = ($urandom_range(0, 9) < 8) ? 16'(good) : 16'($urandom);
      end
      cyc(($urandom_range(0, 127) != 0), ($urandom_range(0, 99) == 0), ($urandom_range(0, 31) != 0),
          4'($urandom), dd);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/data_order_check.md
# data_order_check

Receive-side checker for the per-channel counting test pattern the ADC capture path inserts in place of live samples. It sits on the DAC/loopback or post-DMA side of the data path, on the same channelized data/enable/valid bus. Per channel, it predicts the next count value, compares it against every qualifying sample, and reports lock state, mismatch pulses, sticky errors and saturating error counts.

## Interface
Parameters:
- NUM_CHANNELS, 4, number of channels on the bus
- CHANNEL_OFFSET, 1024, seed spacing: channel i seeds at (CHANNEL_OFFSET*i) mod 2^CHANNEL_WIDTH
- CHANNEL_WIDTH, 16, bits per channel sample
- ERR_WIDTH, 16, width of each per-channel error counter
- STRICT_START, 0, 1 = the first sample after arming must equal the channel seed; 0 = the first sample seeds the prediction

Ports:
- adc_clk  in  1  sole clock
- adc_rstn  in  1  reset, synchronous, active-low
- check_en  in  1  checker enable; low forces all channels to IDLE
- reset_count  in  1  synchronous re-arm: clears state and counters, same effect as reset
- adc_data_in  in  NUM_CHANNELS*CHANNEL_WIDTH  channel i at bits [CHANNEL_WIDTH*(i+1)-1 : CHANNEL_WIDTH*i]
- adc_enable_in  in  NUM_CHANNELS  per-channel enable
- adc_valid_in  in  NUM_CHANNELS  per-channel valid
- check_lock  out  NUM_CHANNELS  channel is in TRACK
- check_err_pulse  out  NUM_CHANNELS  one-cycle pulse per mismatch
- check_err  out  NUM_CHANNELS  sticky mismatch flag
- err_count  out  NUM_CHANNELS*ERR_WIDTH  saturating per-channel mismatch count, packed like data

## Operation
- Qualifying sample on channel i: adc_enable_in[i] & adc_valid_in[i] & check_en.
- Each channel runs its own state machine with states IDLE, WAIT_SEED and TRACK. Each channel also holds an expected register exp[i] of CHANNEL_WIDTH bits.
- IDLE: entered whenever check_en=0. Counters and sticky flags hold their values. Goes to WAIT_SEED on the first cycle check_en=1.
- WAIT_SEED, STRICT_START=0: on the first qualifying sample d, set exp <= d+1 and go to TRACK. No comparison is made.
- WAIT_SEED, STRICT_START=1: a qualifying sample equal to the seed sets exp <= seed+1 and goes to TRACK. Any other value counts as a mismatch and the channel stays in WAIT_SEED.
- TRACK, d == exp: set exp <= exp+1.
- TRACK, d != exp: mismatch. Pulse check_err_pulse[i], set check_err[i], increment err_count[i]. exp update follows the Configuration section. The channel stays in TRACK.
- All arithmetic is modulo 2^CHANNEL_WIDTH. 0xFFFF followed by 0x0000 is a match. Seeds wrap the same way, e.g. CHANNEL_OFFSET=32768, i=2 gives seed 0.
- err_count saturates at 2^ERR_WIDTH-1. Further mismatches still pulse and keep check_err set.
- Channels with enable=0 or valid=0 hold all of their state.

## Timing
- All outputs are registered. A sample at edge n is reflected in check_lock, check_err_pulse, check_err and err_count after edge n. Latency is 1 cycle.
- Reset (adc_rstn=0 or reset_count=1 at a clock edge) has priority over everything else. After reset: state = IDLE if check_en=0, else WAIT_SEED; exp=0; check_lock=0; check_err_pulse=0; check_err=0; err_count=0.
- A qualifying sample in the same cycle as reset is discarded.
- Reset mid-TRACK drops lock on the next edge. The next qualifying sample is treated as a fresh seed.
- check_en falling while in TRACK: the channel goes to IDLE and check_lock drops on the next edge. Any sample in that cycle is ignored.
- check_err_pulse is high for exactly one cycle per mismatching sample. Back-to-back mismatches produce a continuous high.

## Configuration
- DATA_ORDER_CHECK_RESYNC_EN defined: on a TRACK mismatch, exp <= d+1, so the channel resynchronises to the received value. A single dropped or inserted sample costs exactly one error.
- Not defined: on a mismatch, exp <= exp+1 regardless of the received value. After a slip, every subsequent sample mismatches until reset_count is asserted.

## Test plan
- N=4, offset 1024, STRICT_START=1, check_en=1. Feed ideal streams ch0 0,1,2… and ch3 3072,3073,… for 100 samples -> check_lock=4'b1111 one cycle after each first sample; err_count all 0; check_err=0.
- ch1 counts 1024…0xFFFF then 0x0000, 0x0001 (offset 1024, wrap) -> no errors; lock held.
- With RESYNC_EN, ch2 stream 2048,2049,2051,2052 -> exactly one pulse, on the 2051 cycle; err_count[2]=1. Without RESYNC_EN -> pulses on 2051 and 2052; err_count[2]=2 and keeps rising.
- STRICT_START=1, ch0 first sample 5 -> one error, state stays WAIT_SEED, check_lock[0]=0. A following 0 -> check_lock[0]=1.
- ERR_WIDTH=4, forced continuous mismatches -> err_count saturates at 15; pulses continue.
- Assert reset_count for 1 cycle while in TRACK with check_err=1 -> next cycle all outputs are 0; the next sample reseeds.
